fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 74 +++++++
 tb/tb_fifo_wr_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared defaults and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;
  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 4;
  localparam int DEPTH_DEF     = 8;
  localparam int MAX_BURST_DEF = 2;
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot pick of the first request searching circularly from last+1.
module rr_pick #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  pick
);
  logic [LW-1:0] idx;
  logic          found;
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = LW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter for a shared FIFO write port with occupancy tracking.
// Define FIFO_ARB_BURST_EN to let an owner hold the grant for up to MAX_BURST cycles.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        fifo_w_en,
  output logic [DATA_W-1:0]           fifo_data_in,
  input  logic                        fifo_r_en,
  output logic [level_w(DEPTH)-1:0]   level
);
  localparam int LW = idx_w(NUM_REQ);
  localparam int VW = level_w(DEPTH);
  logic [LW-1:0]      last_q, last_d;
  logic [VW-1:0]      level_q, level_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               w_en_q;
  logic [NUM_REQ-1:0] rr, pick;
  logic               full, grant, rd_ok;
  rr_pick #(.N(NUM_REQ), .LW(LW)) u_rr (.req(req), .last(last_q), .pick(rr));
  assign full = level_q == VW'(DEPTH);
`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] cnt_q, cnt_d;
  logic          hold;
  // cnt_q counts consecutive grants in the current burst; a fresh round-robin win restarts it
  assign hold  = cnt_q != '0 && cnt_q < BW'(MAX_BURST) && req[last_q] && !full;
  assign pick  = hold ? (NUM_REQ'(1) << last_q) : rr;
  assign cnt_d = !grant ? '0 : hold ? cnt_q + BW'(1) : BW'(1);
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
`else
  localparam int unused_max_burst = MAX_BURST;
  assign pick = rr;
`endif
  assign gnt     = (!rst_n || full) ? '0 : pick;
  assign grant   = |gnt;
  assign rd_ok   = fifo_r_en && level_q != '0;
  assign level_d = level_q + VW'(grant) - VW'(rd_ok);
  always_comb begin
    data_d = data_q;
    last_d = last_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        data_d = req_data[i*DATA_W +: DATA_W];
        last_d = LW'(i);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en_q  <= 1'b0;
      data_q  <= '0;
      level_q <= '0;
      last_q  <= LW'(NUM_REQ - 1);
    end else begin
      w_en_q  <= grant;
      data_q  <= data_d;
      level_q <= level_d;
      last_q  <= last_d;
    end
  end
  assign fifo_w_en    = w_en_q;
  assign fifo_data_in = data_q;
  assign level        = level_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;
  localparam int N = 4, DW = 4, D = 8, MB = 2;
  logic clk = 1'b0, rst_n = 1'b0, fifo_r_en = 1'b0, fifo_w_en;
  logic [N-1:0] req = '0, gnt;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0] fifo_data_in;
  logic [level_w(D)-1:0] level;
  int vectors = 0, miscompares = 0;
  int m_last = N - 1, m_level = 0, m_bcnt = 0;
  logic m_wen = 1'b0;
  logic [DW-1:0] m_data = '0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in), .fifo_r_en(fifo_r_en), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_gnt(output bit hold);
    hold = 1'b0;
    if (!rst_n || m_level == D || req == '0) return '0;
`ifdef FIFO_ARB_BURST_EN
    if (m_bcnt > 0 && m_bcnt < MB && req[m_last]) begin
      hold = 1'b1;
      return N'(1) << m_last;
    end
`endif
    for (int k = 1; k <= N; k++)
      if (req[(m_last + k) % N]) return N'(1) << ((m_last + k) % N);
    return '0;
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic ren);
    req = r;
    req_data = d;
    fifo_r_en = ren;
    #1;
  endtask

  task automatic tick;
    logic [N-1:0] g;
    bit h;
    int idx;
    g = model_gnt(h);
    @(posedge clk);
    if (!rst_n) begin
      m_wen = 1'b0; m_data = '0; m_level = 0; m_last = N - 1; m_bcnt = 0;
    end else begin
      m_wen = g != '0;
      if (g != '0) begin
        idx = $clog2(g);
        m_data = req_data[idx*DW +: DW];
        m_bcnt = h ? m_bcnt + 1 : 1;
        m_last = idx;
      end else m_bcnt = 0;
      m_level = m_level + int'(g != '0) - int'(fifo_r_en && m_level > 0);
    end
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(4'b1111, 16'h4321, 1'b0);
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt_forced: got %b want 0000", gnt); end
    tick();
    tick();
    rst_n = 1'b1;
    drive('0, '0, 1'b0);
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    vectors++; if (fifo_w_en !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b want 0", fifo_w_en); end
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
    vectors++; if (fifo_data_in !== 4'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", fifo_data_in); end
    tick();
    vectors++; if (fifo_w_en !== 1'b0 || level !== 4'd0) begin miscompares++; $display("FAIL reset_idle: got wen=%b level=%0d want 0/0", fifo_w_en, level); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] eg [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 16'h4321, 1'b0);
      vectors++; if (gnt !== eg[i]) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, eg[i]); end
      tick();
      vectors++; if (fifo_w_en !== 1'b1) begin miscompares++; $display("FAIL rr_wen[%0d]: got %b want 1", i, fifo_w_en); end
      vectors++; if (fifo_data_in !== 4'(i % 4 + 1)) begin miscompares++; $display("FAIL rr_data[%0d]: got %h want %h", i, fifo_data_in, i % 4 + 1); end
      vectors++; if (level !== 4'(i + 1)) begin miscompares++; $display("FAIL rr_level[%0d]: got %0d want %0d", i, level, i + 1); end
    end
  endtask

  task automatic test_burst;
    logic [N-1:0] eg [5];
    eg = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0011, 16'h00BA, 1'b0);
      vectors++; if (gnt !== eg[i]) begin miscompares++; $display("FAIL burst_gnt[%0d]: got %b want %b", i, gnt, eg[i]); end
      tick();
    end
  endtask

  task automatic test_full_stall;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b0001, 16'h000A, 1'b0);
      vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL fill_gnt[%0d]: got %b want 0001", i, gnt); end
      tick();
    end
    vectors++; if (level !== 4'd8) begin miscompares++; $display("FAIL fill_level: got %0d want 8", level); end
    drive(4'b0001, 16'h000A, 1'b0);
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL full_gnt: got %b want 0000", gnt); end
    tick();
    vectors++; if (fifo_w_en !== 1'b0 || level !== 4'd8) begin miscompares++; $display("FAIL full_hold: got wen=%b level=%0d want 0/8", fifo_w_en, level); end
    drive(4'b0001, 16'h000A, 1'b1);
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL full_read_gnt: got %b want 0000", gnt); end
    tick();
    vectors++; if (level !== 4'd7) begin miscompares++; $display("FAIL full_read_level: got %0d want 7", level); end
    drive(4'b0001, 16'h000A, 1'b0);
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL refill_gnt: got %b want 0001", gnt); end
    tick();
    vectors++; if (level !== 4'd8 || fifo_w_en !== 1'b1) begin miscompares++; $display("FAIL refill: got level=%0d wen=%b want 8/1", level, fifo_w_en); end
  endtask

  task automatic test_grant_read;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 16'h0005, 1'b0);
      tick();
    end
    vectors++; if (level !== 4'd3) begin miscompares++; $display("FAIL gr_pre_level: got %0d want 3", level); end
    drive(4'b0001, 16'h0006, 1'b1);
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL gr_gnt: got %b want 0001", gnt); end
    tick();
    vectors++; if (level !== 4'd3 || fifo_data_in !== 4'h6) begin miscompares++; $display("FAIL gr_level: got level=%0d data=%h want 3/6", level, fifo_data_in); end
    for (int i = 0; i < 3; i++) begin
      drive('0, '0, 1'b1);
      tick();
    end
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL drain_level: got %0d want 0", level); end
    drive('0, '0, 1'b1);
    tick();
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL underflow: got %0d want 0", level); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 16'h0009, 1'b0);
      tick();
    end
    vectors++; if (fifo_w_en !== 1'b1 || level !== 4'd5) begin miscompares++; $display("FAIL mid_pre: got wen=%b level=%0d want 1/5", fifo_w_en, level); end
    rst_n = 1'b0;
    drive(4'b0001, 16'h0009, 1'b0);
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL mid_gnt: got %b want 0000", gnt); end
    tick();
    vectors++; if (fifo_w_en !== 1'b0 || level !== 4'd0 || gnt !== 4'b0000) begin miscompares++; $display("FAIL mid_reset: got wen=%b level=%0d gnt=%b want 0/0/0000", fifo_w_en, level, gnt); end
    rst_n = 1'b1;
    drive('0, '0, 1'b0);
    tick();
    vectors++; if (fifo_w_en !== 1'b0) begin miscompares++; $display("FAIL mid_after: got wen=%b want 0", fifo_w_en); end
  endtask

  task automatic test_random;
    logic [N-1:0] eg;
    bit h;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(0, 59) != 0;
      drive($urandom_range(0, 3) == 0 ? '0 : N'($urandom), (N*DW)'($urandom), $urandom_range(0, 2) == 0);
      eg = model_gnt(h);
      vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL rnd_gnt[%0d]: got %b want %b", i, gnt, eg); end
      tick();
      vectors++; if (fifo_w_en !== m_wen) begin miscompares++; $display("FAIL rnd_wen[%0d]: got %b want %b", i, fifo_w_en, m_wen); end
      vectors++; if (fifo_data_in !== m_data) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h want %h", i, fifo_data_in, m_data); end
      vectors++; if (level !== 4'(m_level)) begin miscompares++; $display("FAIL rnd_level[%0d]: got %0d want %0d", i, level, m_level); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`else
    test_round_robin();
`endif
    test_full_stall();
    test_grant_read();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
